// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller sitting between peripherals and the CPU.
// Masks level IRQs, requests one winner, clears it on ack, cools down on return.
module irq_controller #(
    parameter int unsigned              NUM_SOURCES = 4,
    parameter logic [NUM_SOURCES-1:0]   MASK_RESET  = {NUM_SOURCES{1'b1}}
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] src_irq,
    output logic [NUM_SOURCES-1:0] src_reset_irq,
    output logic                   cpu_irq,
    input  logic                   cpu_irq_ack,
    input  logic                   cpu_irq_ret,
    output logic [3:0]             irq_cause,
    input  logic                   mask_wr,
    input  logic [NUM_SOURCES-1:0] mask_wdata,
    output logic [NUM_SOURCES-1:0] mask,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACTIVE,
        S_COOL
    } state_e;

    localparam logic [NUM_SOURCES-1:0] ONE = NUM_SOURCES'(1);

    state_e                 state_q, state_d;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] mask_q, mask_d;
    logic [NUM_SOURCES-1:0] clr_q, clr_d;
    logic [3:0]             cause_q, cause_d;
    logic                   irq_q, irq_d;
    logic                   busy_q, busy_d;
    logic [NUM_SOURCES-1:0] eff_mask;
    logic [NUM_SOURCES-1:0] cause_sel;

    // Lowest set index wins; index 0 is the highest priority.
    function automatic logic [3:0] lowest(input logic [NUM_SOURCES-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Next-state, mask/pending update and handshake sequencing.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        irq_d     = irq_q;
        clr_d     = '0;
        eff_mask  = mask_wr ? mask_wdata : mask_q;
        mask_d    = eff_mask;
        pending_d = src_irq & eff_mask;
        cause_sel = ONE << cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    cause_d = lowest(pending_q);
                    irq_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (cpu_irq_ack) begin
                    irq_d   = 1'b0;
                    clr_d   = cause_sel;
                    state_d = S_ACTIVE;
                end else if ((eff_mask & cause_sel) == '0) begin
                    irq_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (cpu_irq_ret) state_d = S_COOL;
            end
            S_COOL: begin
                state_d = S_IDLE;
            end
            default: begin
                irq_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            mask_q    <= MASK_RESET;
            clr_q     <= '0;
            cause_q   <= '0;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            clr_q     <= clr_d;
            cause_q   <= cause_d;
            irq_q     <= irq_d;
            busy_q    <= busy_d;
        end
    end

    assign src_reset_irq = clr_q;
    assign cpu_irq       = irq_q;
    assign irq_cause     = cause_q;
    assign mask          = mask_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed handshake scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_irq_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] src_irq;
    logic [3:0] src_reset_irq;
    logic       cpu_irq;
    logic       cpu_irq_ack;
    logic       cpu_irq_ret;
    logic [3:0] irq_cause;
    logic       mask_wr;
    logic [3:0] mask_wdata;
    logic [3:0] mask;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: where the controller is in its service of an IRQ.
    // 0 = free, 1 = requesting, 2 = in handler, 3 = settling after return.
    int         m_where;
    logic [3:0] m_pend, m_mask, m_cause, m_clr;
    logic       m_irq;

    irq_controller #(.NUM_SOURCES(4), .MASK_RESET(4'b1111)) dut (
        .clock         (clock),
        .reset         (reset),
        .src_irq       (src_irq),
        .src_reset_irq (src_reset_irq),
        .cpu_irq       (cpu_irq),
        .cpu_irq_ack   (cpu_irq_ack),
        .cpu_irq_ret   (cpu_irq_ret),
        .irq_cause     (irq_cause),
        .mask_wr       (mask_wr),
        .mask_wdata    (mask_wdata),
        .mask          (mask),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        logic [3:0] eff, lo, sel;
        if (reset) begin
            m_where = 0; m_pend = 0; m_mask = 4'b1111;
            m_cause = 0; m_irq = 0; m_clr = 0;
            return;
        end
        eff   = mask_wr ? mask_wdata : m_mask;
        sel   = 4'(1 << m_cause);
        m_clr = 4'b0000;
        case (m_where)
            0: if (m_pend != 0) begin
                lo      = m_pend & (~m_pend + 4'd1);
                m_cause = 4'($clog2(lo));
                m_irq   = 1;
                m_where = 1;
            end
            1: if (cpu_irq_ack) begin
                m_irq   = 0;
                m_clr   = sel;
                m_where = 2;
            end else if ((eff & sel) == 0) begin
                m_irq   = 0;
                m_where = 0;
            end
            2: if (cpu_irq_ret) m_where = 3;
            default: m_where = 0;
        endcase
        m_mask = eff;
        m_pend = src_irq & eff;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk("model", {18'b0, cpu_irq, irq_cause, src_reset_irq, mask, busy},
            {18'b0, m_irq, m_cause, m_clr, m_mask, m_where != 0});
    endtask

    task automatic wait_irq();
        int n = 0;
        while (!cpu_irq && n < 8) begin
            tick();
            n++;
        end
        chk("wait_irq", {31'b0, cpu_irq}, 32'd1);
    endtask

    task automatic settle();
        src_irq = 0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1; src_irq = 4'b1111; cpu_irq_ack = 0; cpu_irq_ret = 0;
        mask_wr = 0; mask_wdata = 0;

        // Reset sequencing
        tick(); tick();
        chk("rst_irq", {31'b0, cpu_irq}, 0);
        chk("rst_mask", {28'b0, mask}, 32'hf);
        chk("rst_cause", {28'b0, irq_cause}, 0);
        reset = 0;
        tick();
        chk("rel_irq_e0", {31'b0, cpu_irq}, 0);
        tick();
        chk("rel_irq_e1", {31'b0, cpu_irq}, 1);
        chk("rel_cause", {28'b0, irq_cause}, 0);
        cpu_irq_ack = 1; tick(); cpu_irq_ack = 0;
        chk("rel_clr", {28'b0, src_reset_irq}, 32'h1);
        src_irq = 0; tick();
        cpu_irq_ret = 1; tick(); cpu_irq_ret = 0;
        tick();
        chk("rel_idle", {31'b0, busy}, 0);
        settle();

        // Single source, full handshake
        src_irq = 4'b0100;
        wait_irq();
        tick(); tick();
        cpu_irq_ack = 1; tick(); cpu_irq_ack = 0;
        chk("one_cause", {28'b0, irq_cause}, 2);
        chk("one_clr", {28'b0, src_reset_irq}, 32'h4);
        chk("one_irq", {31'b0, cpu_irq}, 0);
        src_irq = 0; tick();
        chk("one_clr_once", {28'b0, src_reset_irq}, 0);
        cpu_irq_ret = 1; tick(); cpu_irq_ret = 0;
        chk("one_cool", {31'b0, busy}, 1);
        tick();
        chk("one_idle", {31'b0, busy}, 0);
        settle();

        // Priority and no preemption
        src_irq = 4'b1000;
        wait_irq();
        chk("pri_cause3", {28'b0, irq_cause}, 3);
        src_irq = 4'b1001; tick(); tick();
        chk("pri_hold", {28'b0, irq_cause}, 3);
        chk("pri_hold_irq", {31'b0, cpu_irq}, 1);
        cpu_irq_ack = 1; tick(); cpu_irq_ack = 0;
        chk("pri_clr", {28'b0, src_reset_irq}, 32'h8);
        src_irq = 4'b0001; tick();
        cpu_irq_ret = 1; tick(); cpu_irq_ret = 0;
        tick();
        wait_irq();
        chk("pri_next", {28'b0, irq_cause}, 0);
        cpu_irq_ack = 1; tick(); cpu_irq_ack = 0;
        src_irq = 0; tick();
        cpu_irq_ret = 1; tick(); cpu_irq_ret = 0;
        settle();

        // Masking blocks a source entirely
        mask_wr = 1; mask_wdata = 4'b1110; src_irq = 4'b0001;
        tick(); mask_wr = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("msk_block", {31'b0, cpu_irq}, 0);
        end
        src_irq = 0;
        mask_wr = 1; mask_wdata = 4'b1111; tick(); mask_wr = 0;
        settle();

        // Masking withdraws an outstanding request
        src_irq = 4'b0010;
        wait_irq();
        chk("wd_cause", {28'b0, irq_cause}, 1);
        mask_wr = 1; mask_wdata = 4'b1101; tick(); mask_wr = 0;
        chk("wd_irq", {31'b0, cpu_irq}, 0);
        chk("wd_idle", {31'b0, busy}, 0);
        mask_wr = 1; mask_wdata = 4'b1111; tick(); mask_wr = 0;
        wait_irq();

        // Ack beats a coincident masking write
        mask_wr = 1; mask_wdata = 4'b1101; cpu_irq_ack = 1;
        tick(); mask_wr = 0; cpu_irq_ack = 0;
        chk("ackw_busy", {31'b0, busy}, 1);
        chk("ackw_clr", {28'b0, src_reset_irq}, 32'h2);
        src_irq = 0; tick();
        cpu_irq_ret = 1; tick(); cpu_irq_ret = 0;
        mask_wr = 1; mask_wdata = 4'b1111; tick(); mask_wr = 0;
        settle();

        // Spurious strobes
        cpu_irq_ack = 1; tick(); cpu_irq_ack = 0;
        chk("sp_ack_busy", {31'b0, busy}, 0);
        chk("sp_ack_clr", {28'b0, src_reset_irq}, 0);
        src_irq = 4'b0100;
        wait_irq();
        cpu_irq_ret = 1; tick(); cpu_irq_ret = 0;
        chk("sp_ret_irq", {31'b0, cpu_irq}, 1);
        chk("sp_ret_clr", {28'b0, src_reset_irq}, 0);

        // Reset while in the handler
        cpu_irq_ack = 1; tick(); cpu_irq_ack = 0;
        tick();
        reset = 1; tick(); reset = 0;
        chk("mr_busy", {31'b0, busy}, 0);
        chk("mr_clr", {28'b0, src_reset_irq}, 0);
        chk("mr_irq", {31'b0, cpu_irq}, 0);
        tick();
        chk("mr_irq_e0", {31'b0, cpu_irq}, 0);
        tick();
        chk("mr_irq_e1", {31'b0, cpu_irq}, 1);
        chk("mr_cause", {28'b0, irq_cause}, 2);
        cpu_irq_ack = 1; tick(); cpu_irq_ack = 0;
        src_irq = 0; tick();
        cpu_irq_ret = 1; tick(); cpu_irq_ret = 0;
        settle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                src_irq = src_irq ^ 4'($urandom_range(0, 15));
            if (m_clr != 0 && $urandom_range(0, 1) == 0)
                src_irq = src_irq & ~m_clr;
            cpu_irq_ack = ($urandom_range(0, 2) == 0);
            cpu_irq_ret = ($urandom_range(0, 3) == 0);
            mask_wr     = ($urandom_range(0, 9) == 0);
            mask_wdata  = 4'($urandom_range(0, 15));
            reset       = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
